md_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers, in the EX stage beside the ALU.
- Executes mult/multu/div/divu and mthi/mtlo.
- Exposes HI/LO for mfhi/mflo results, which flow into the EX/MEM latch.
- Drives busy so hazard logic stalls later MD instructions in ID.

---
 rtl/md_if.sv | 14 +
 rtl/md_unit.sv | 123 ++++++++++++
 tb/tb_md_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/md_if.sv
// Bus between EX-stage control and the multiply/divide unit: the
// instruction strobe and operands in, busy and the HI/LO registers out.
interface md_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers, beside the EX-stage ALU.
// Define MD_MADD_EN to enable the madd/maddu accumulate ops (op 6/7).
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  // Counter holds cycles-1 at most, so it needs clog2(cycles) bits.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      hi_q, lo_q;

  logic        is_div_op, is_long_op, accept;
  logic [63:0] prod_s, prod_u, res;
  logic        res_we;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_div_op  = (md.op == OP_DIV) || (md.op == OP_DIVU);
`ifdef MD_MADD_EN
    is_long_op = (md.op <= OP_DIVU) || (md.op == OP_MADD) || (md.op == OP_MADDU);
`else
    is_long_op = (md.op <= OP_DIVU);
`endif
    accept     = md.start && (state == S_IDLE) && is_long_op;
  end

  // Signed divide works on magnitudes, then restores signs: the quotient
  // truncates toward zero and the remainder follows the dividend. This also
  // gives 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    a_neg  = (op_q == OP_DIV) && a_q[31];
    b_neg  = (op_q == OP_DIV) && b_q[31];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    q_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    r_mag  = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    res_we = 1'b1;
    res    = prod_s;
    case (op_q)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV, OP_DIVU: begin
        res_we = (b_q != 32'd0);
        res    = {(a_neg ? -r_mag : r_mag), ((a_neg ^ b_neg) ? -q_mag : q_mag)};
      end
`ifdef MD_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + prod_s;
      OP_MADDU: res = {hi_q, lo_q} + prod_u;
`endif
      default:  res_we = 1'b0;
    endcase
  end

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q  <= md.op;
            a_q   <= md.a;
            b_q   <= md.b;
            cnt   <= is_div_op ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            state <= S_RUN;
          end else if (md.start && md.op == OP_MTHI) begin
            hi_q <= md.a;
          end else if (md.start && md.op == OP_MTLO) begin
            lo_q <= md.a;
          end
        end
        default: begin
          if (cnt == '0) begin
            if (res_we) {hi_q, lo_q} <= res;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign md.busy = (state == S_RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal results plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_md_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic clk = 1'b0;
  logic reset;
  md_if bus ();

  md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_long(input logic [2:0] op);
`ifdef MD_MADD_EN
    return (op <= 3'd3) || (op >= 3'd6);
`else
    return (op <= 3'd3);
`endif
  endfunction

  function automatic bit ref_we(input logic [2:0] op, input logic [31:0] b);
    return !((op == 3'd2 || op == 3'd3) && b == 32'd0);
  endfunction

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: return (b == 0) ? acc : {32'(sa % sb), 32'(sa / sb)};
      3'd3: return (b == 0) ? acc : {32'(ua % ub), 32'(ua / ub)};
      3'd6: return acc + 64'(sa * sb);
      3'd7: return acc + ua * ub;
      default: return acc;
    endcase
  endfunction

  int unsigned m_rem;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  bit          m_we;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem <= 0;
      m_hi  <= '0;
      m_lo  <= '0;
      m_we  <= 1'b0;
      m_res <= '0;
    end else if (m_rem != 0) begin
      if (m_rem == 1 && m_we) {m_hi, m_lo} <= m_res;
      m_rem <= m_rem - 1;
    end else if (bus.start) begin
      if (bus.op == 3'd4) m_hi <= bus.a;
      else if (bus.op == 3'd5) m_lo <= bus.a;
      else if (is_long(bus.op)) begin
        m_we  <= ref_we(bus.op, bus.b);
        m_res <= ref_res(bus.op, bus.a, bus.b, {m_hi, m_lo});
        m_rem <= (bus.op == 3'd2 || bus.op == 3'd3) ? DIV_CYCLES : MULT_CYCLES;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("cyc_busy", {63'b0, bus.busy}, {63'b0, (m_rem != 0)});
      check("cyc_hi", {32'b0, bus.hi}, {32'b0, m_hi});
      check("cyc_lo", {32'b0, bus.lo}, {32'b0, m_lo});
    end
  end

  // ---------------- stimulus ----------------
  // Issue one op at a negedge, then count busy cycles until the unit is idle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_hi", {32'b0, bus.hi}, 64'd0);
    check("reset_lo", {32'b0, bus.lo}, 64'd0);
    reset = 1'b0;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, n);
    check("mult_cycles", 64'(n), 64'd5);
    check("mult_hi", {32'b0, bus.hi}, 64'hFFFF_FFFF);
    check("mult_lo", {32'b0, bus.lo}, 64'hFFFF_FFFA);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    check("div_cycles", 64'(n), 64'd10);
    check("div_lo", {32'b0, bus.lo}, 64'hFFFF_FFFD);
    check("div_hi", {32'b0, bus.hi}, 64'hFFFF_FFFF);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
    check("divu_lo", {32'b0, bus.lo}, 64'h7FFF_FFFC);
    check("divu_hi", {32'b0, bus.hi}, 64'h1);

    run_op(3'd4, 32'h11, 32'd0, n);
    run_op(3'd5, 32'h22, 32'd0, n);
    run_op(3'd2, 32'd1234, 32'd0, n);
    check("div0_cycles", 64'(n), 64'd10);
    check("div0_hi", {32'b0, bus.hi}, 64'h11);
    check("div0_lo", {32'b0, bus.lo}, 64'h22);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divovf_lo", {32'b0, bus.lo}, 64'h8000_0000);
    check("divovf_hi", {32'b0, bus.hi}, 64'h0);

    run_op(3'd4, 32'hDEAD_BEEF, 32'd0, n);
    check("mthi_busy", 64'(n), 64'd0);
    check("mthi_hi", {32'b0, bus.hi}, 64'hDEAD_BEEF);

    // Start while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd6;
    @(negedge clk);
    bus.op = 3'd5; bus.a = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin n++; @(negedge clk); end
    check("busy_start_lo", {32'b0, bus.lo}, 64'd30);
    check("busy_start_hi", {32'b0, bus.hi}, 64'd0);

`ifdef MD_MADD_EN
    run_op(3'd4, 32'd0, 32'd0, n);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd0, n);
    run_op(3'd7, 32'd1, 32'd1, n);
    check("maddu_cycles", 64'(n), 64'd5);
    check("maddu_hi", {32'b0, bus.hi}, 64'h1);
    check("maddu_lo", {32'b0, bus.lo}, 64'h0);
`else
    run_op(3'd6, 32'd7, 32'd9, n);
    check("madd_off_busy", 64'(n), 64'd0);
    check("madd_off_hi", {32'b0, bus.hi}, 64'd0);
    check("madd_off_lo", {32'b0, bus.lo}, 64'd30);
`endif

    // Randomized traffic, including strobes during busy and corner operands.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.op    = 3'($urandom_range(0, 7));
      bus.a     = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       bus.b = 32'd0;
        1:       bus.b = 32'($urandom_range(1, 9));
        2:       bus.b = 32'hFFFF_FFFF;
        default: bus.b = $urandom;
      endcase
    end
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin n++; @(negedge clk); end
    check("rand_drain", {63'b0, bus.busy}, 64'd0);

    // Reset on the third busy cycle of a divide aborts it.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_mid_hi", {32'b0, bus.hi}, 64'd0);
    check("rst_mid_lo", {32'b0, bus.lo}, 64'd0);
    #1 reset = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_after_hi", {32'b0, bus.hi}, 64'd0);
    check("rst_after_lo", {32'b0, bus.lo}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
